shift_sequencer: RTL and testbench

Command-driven controller that sits directly upstream of the team's 4-bit bidirectional shift register. It drives the register's `d`, `ld`, `l_r` and `s` inputs and watches the register's `q` output. A command carries a word, a direction, a shift count, a fill bit and a rotate flag. The block loads the word, issues exactly the requested number of single-bit shifts (logical or rotate), then returns the result over a valid/ready handshake. Between operations it holds the register's contents by reloading `q`, because the register shifts every cycle that `ld` is low.

---
 rtl/shift_sequencer.sv | 110 +++++++++++
 tb/tb_shift_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a 4-bit bidirectional shift register: loads a word,
// issues N single-bit shifts (logical or rotate), then returns the result on a handshake.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic             cmd_rot,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] d,
  output logic             ld,
  output logic             l_r,
  output logic             s,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic             rot_q, rot_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    rot_d   = rot_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          data_d  = cmd_data;
          count_d = cmd_count;
          dir_d   = cmd_dir;
          fill_d  = cmd_fill;
          rot_d   = cmd_rot;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = count_q;
        state_d = (count_q != '0) ? S_SHIFT : S_RESULT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // <=1 rather than ==1 so a corrupted zero count cannot spin forever
        if (cnt_q <= CNT_W'(1)) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      rot_q   <= rot_d;
    end
  end

  // The register shifts whenever ld is low, so every non-SHIFT state reloads q to hold it.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    res_valid = (state_q == S_RESULT);
    res_data  = q;
    ld        = (state_q != S_SHIFT);
    d         = (state_q == S_LOAD) ? data_q : q;
    l_r       = 1'b0;
    s         = 1'b0;
    if (state_q == S_SHIFT) begin
      l_r = dir_q;
      if (rot_q) s = dir_q ? q[WIDTH-1] : q[0];
      else       s = fill_q;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer: drives it against a behavioural shift register
// and compares results and cycle timing with an arithmetic reference model.
module tb_shift_sequencer;
  localparam int W = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_count = '0;
  logic          cmd_fill = 1'b0;
  logic          cmd_rot = 1'b0;
  logic [W-1:0]  q;
  logic [W-1:0]  d;
  logic          ld, l_r, s;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_data;
  logic          sr_rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_fill(cmd_fill), .cmd_rot(cmd_rot),
    .q(q), .d(d), .ld(ld), .l_r(l_r), .s(s),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // 4-bit bidirectional shift register the sequencer controls
  always @(posedge clk) begin
    if (sr_rst)   q <= 4'hA;
    else if (ld)  q <= d;
    else if (l_r) q <= {q[W-2:0], s};
    else          q <= {s, q[W-1:1]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [W-1:0] dat, input logic dir,
                                           input int n, input logic fill, input logic rot);
    logic [2*W-1:0] dd;
    logic [W-1:0]   ones, r;
    int m;
    ones = '1;
    if (rot) begin
      m  = n % W;
      dd = {dat, dat};
      if (dir) begin dd = dd << m; r = dd[2*W-1:W]; end
      else     begin dd = dd >> m; r = dd[W-1:0];   end
    end else if (n >= W) begin
      r = {W{fill}};
    end else if (dir) begin
      r = (dat << n) | (fill ? (ones >> (W - n)) : '0);
    end else begin
      r = (dat >> n) | (fill ? ~(ones >> n) : '0);
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Call at a negedge with the block idle; returns at a negedge after the result handshake.
  task automatic run_cmd(input logic [W-1:0] dat, input logic dir, input logic [CW-1:0] n,
                         input logic fill, input logic rot, input int bp, input bit junk);
    logic [W-1:0] exp, held;
    int k, ldlow;
    bit got, busy_bad, stable_bad;
    exp = ref_res(dat, dir, int'(n), fill, rot);
    chk("pre_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_data = dat; cmd_dir = dir; cmd_count = n;
    cmd_fill = fill; cmd_rot = rot; res_ready = (bp == 0);
    tick();
    k = 1;
    cmd_valid = 1'b0; cmd_data = W'($urandom); cmd_count = CW'($urandom);
    cmd_dir = 1'($urandom); cmd_fill = 1'($urandom); cmd_rot = 1'($urandom);
    ldlow = 0; got = 0; busy_bad = 0;
    while (!got && k < 40) begin
      if (cmd_ready) busy_bad = 1;
      if (res_valid) got = 1;
      else begin
        if (!ld) ldlow++;
        tick();
        k++;
      end
    end
    chk("res_seen", got, 1);
    chk("latency", k, int'(n) + 2);
    chk("ld_low_cycles", ldlow, int'(n));
    chk("busy_no_ready", busy_bad, 0);
    chk("res_data", res_data, exp);
    held = res_data;
    stable_bad = 0;
    for (int i = 0; i < bp; i++) begin
      if (junk) begin
        cmd_valid = 1'b1; cmd_data = W'($urandom); cmd_count = CW'($urandom);
      end
      if (!res_valid || res_data !== held || cmd_ready) stable_bad = 1;
      tick();
    end
    if (bp > 0) chk("bp_stable", stable_bad, 0);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_ready", cmd_ready, 1);
    chk("post_valid", res_valid, 0);
  endtask

  initial begin
    bit bad;
    logic [W-1:0] rd;
    logic [CW-1:0] rn;
    int k;
    @(negedge clk);
    tick();
    rst = 1'b0; sr_rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ld", ld, 1);
    chk("rst_l_r", l_r, 0);
    chk("rst_s", s, 0);
    chk("rst_d_hold", d, q);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (q !== 4'hA || !ld || !cmd_ready) bad = 1;
      tick();
    end
    chk("idle_hold", bad, 0);
    chk("idle_q", q, 4'hA);

    // directed cases
    run_cmd(4'b1011, 1'b1, 3'd2, 1'b0, 1'b0, 0, 0);
    chk("lsl2_val", res_data, 4'b1100);
    run_cmd(4'b0001, 1'b0, 3'd1, 1'b0, 1'b1, 0, 0);
    run_cmd(4'b1001, 1'b1, 3'd5, 1'b0, 1'b1, 0, 0);
    run_cmd(4'b0110, 1'b0, 3'd0, 1'b1, 1'b0, 0, 0);
    run_cmd(4'b0000, 1'b0, 3'd7, 1'b1, 1'b0, 0, 0);
    run_cmd(4'b1110, 1'b1, 3'd3, 1'b1, 1'b0, 5, 1);

    // reset in the middle of a 7-shift operation
    chk("mid_pre_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_data = 4'b0101; cmd_dir = 1'b1; cmd_count = 3'd7;
    cmd_fill = 1'b0; cmd_rot = 1'b1; res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    k = 1;
    while (k < 4) begin tick(); k++; end
    chk("mid_in_shift", ld, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_ld", ld, 1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid) bad = 1;
      tick();
    end
    chk("mid_no_result", bad, 0);
    res_ready = 1'b0;
    run_cmd(4'b0011, 1'b0, 3'd2, 1'b1, 1'b0, 1, 0);

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      rd = W'($urandom);
      rn = CW'($urandom);
      run_cmd(rd, 1'($urandom), rn, 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
